cluster_dma_arbiter: RTL and testbench

Shares the single cluster DMA engine request port between `NUM_REQ` requesters: port 0 is the cluster scheduler's packet-copy stream, and the remaining ports are HPU-issued DMA commands. It arbitrates round-robin with lock-in and records the requester ID of every issued transfer in an in-order tag FIFO. Each engine completion pulse (`dma_resp_i`) is routed back to the requester that issued that transfer. The block sits between the cluster scheduler/HPU command units and the cluster DMA engine.

---
 rtl/cluster_dma_arbiter_pkg.sv | 18 +
 rtl/fifo_v3.sv | 73 +++++++
 rtl/cluster_dma_arbiter.sv | 141 ++++++++++++++
 tb/tb_cluster_dma_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_dma_arbiter_pkg.sv
// Shared types for the cluster DMA arbiter: requester ID, arbiter state, round-robin helper.
// IDs are a fixed width wide enough for any supported requester count.
package cluster_dma_arbiter_pkg;

    localparam int unsigned MAX_NUM_REQ = 16;

    typedef logic [$clog2(MAX_NUM_REQ)-1:0] req_id_t;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } arb_state_e;

    function automatic req_id_t rr_next(input req_id_t id, input int unsigned num_req);
        return (id == req_id_t'(num_req - 1)) ? '0 : id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic flop-based FIFO, DEPTH a power of two (>= 2).
// Latency: push visible at data_o the next cycle. Backpressure: push ignored when full, pop ignored when empty.
// Push and pop together move data without changing the count.
module fifo_v3 #(
    parameter int unsigned DEPTH = 16,
    parameter type         dtype = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   usage_o,
    input  dtype                     data_i,
    input  logic                     push_i,
    output dtype                     data_o,
    input  logic                     pop_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dtype          mem_q [DEPTH];
    dtype          mem_d [DEPTH];
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/cluster_dma_arbiter.sv
// Shares the cluster DMA request port between NUM_REQ requesters, round-robin with lock-in.
// Latency: 0 cycles request->engine and completion->resp_o (combinational paths).
// Backpressure: engine ready passes straight to the granted requester; no grant while the tag FIFO is full.
module cluster_dma_arbiter
    import cluster_dma_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter type         dma_xfer_t   = logic
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  dma_xfer_t [NUM_REQ-1:0]           req_xfer_i,
    output logic                              dma_xfer_valid_o,
    input  logic                              dma_xfer_ready_i,
    output dma_xfer_t                         dma_xfer_o,
    input  logic                              dma_resp_i,
    output logic [NUM_REQ-1:0]                resp_o,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight_o,
    output logic                              idle_o,
    output logic                              err_o
);
    arb_state_e state_q, state_d;
    req_id_t    rr_ptr_q, rr_ptr_d;
    req_id_t    lock_id_q, lock_id_d;
    logic       err_q, err_d;

    req_id_t    pick_id, sel_id, tag_head;
    logic       pick_found, xfer_vld, hs, lock_vld;
    logic       tag_full, tag_empty, tag_pop;

    // First valid requester at or after rr_ptr, else the first valid one below it.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req_valid_i[i] && (req_id_t'(i) >= rr_ptr_q)) begin
                pick_found = 1'b1;
                pick_id    = req_id_t'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req_valid_i[i]) begin
                pick_found = 1'b1;
                pick_id    = req_id_t'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        sel_id    = '0;
        xfer_vld  = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (!tag_full && pick_found) begin
                    xfer_vld = 1'b1;
                    sel_id   = pick_id;
                end
            end
            ST_LOCKED: begin
                if (!tag_full) begin
                    xfer_vld = 1'b1;
                end
                sel_id = lock_id_q;
            end
            default: ;
        endcase
        hs = xfer_vld && dma_xfer_ready_i;
        if (hs) begin
            rr_ptr_d = rr_next(sel_id, NUM_REQ);
            state_d  = ST_ARB;
        end else if (xfer_vld) begin
            lock_id_d = sel_id;
            state_d   = ST_LOCKED;
        end
    end

    assign tag_pop = dma_resp_i && !tag_empty;
    assign err_d   = err_q || (dma_resp_i && tag_empty);

    always_comb begin
        dma_xfer_o  = '0;
        req_ready_o = '0;
        resp_o      = '0;
        lock_vld    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer_vld && (sel_id == req_id_t'(i))) begin
                dma_xfer_o = req_xfer_i[i];
            end
            req_ready_o[i] = hs && (sel_id == req_id_t'(i));
            resp_o[i]      = tag_pop && (tag_head == req_id_t'(i));
            if (lock_id_q == req_id_t'(i)) begin
                lock_vld = req_valid_i[i];
            end
        end
    end

    assign dma_xfer_valid_o = xfer_vld;
    assign err_o            = err_q;
    assign idle_o           = (inflight_o == '0) && (state_q == ST_ARB);

    fifo_v3 #(
        .DEPTH (MAX_INFLIGHT),
        .dtype (req_id_t)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .usage_o (inflight_o),
        .data_i  (sel_id),
        .push_i  (hs),
        .data_o  (tag_head),
        .pop_i   (tag_pop)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    // A locked requester must keep its request up until the engine takes it.
    assert property (@(posedge clk_i) disable iff (rst_i) (state_q == ST_LOCKED) |-> lock_vld)
        else $error("requester dropped valid while locked");

endmodule

// File: tb/tb_cluster_dma_arbiter.sv
// Self-checking bench for cluster_dma_arbiter: grant-order and completion scoreboards.
module tb_cluster_dma_arbiter;

    typedef logic [7:0] xfer_t;
    typedef struct {
        int    id;
        xfer_t xfer;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    xfer_t [1:0]     req_xfer;
    logic            xfer_vld;
    logic            dma_rdy;
    xfer_t           xfer_out;
    logic            dma_resp;
    logic [1:0]      resp;
    logic [2:0]      inflight;
    logic            idle;
    logic            err;

    int n_chk  = 0;
    int n_fail = 0;
    int gnt_cnt = 0;
    exp_t exp_q[$];
    int   tag_q[$];

    always #5 clk = ~clk;

    cluster_dma_arbiter #(
        .NUM_REQ      (2),
        .MAX_INFLIGHT (4),
        .dma_xfer_t   (xfer_t)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_xfer_i       (req_xfer),
        .dma_xfer_valid_o (xfer_vld),
        .dma_xfer_ready_i (dma_rdy),
        .dma_xfer_o       (xfer_out),
        .dma_resp_i       (dma_resp),
        .resp_o           (resp),
        .inflight_o       (inflight),
        .idle_o           (idle),
        .err_o            (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input int id, input xfer_t x);
        exp_t e;
        e.id   = id;
        e.xfer = x;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20; c++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check_eq("grant_drain", exp_q.size(), 0);
    endtask

    task automatic resp_n(input int n);
        for (int k = 0; k < n; k++) begin
            dma_resp = 1'b1;
            tick();
        end
        dma_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        dma_resp  = 1'b0;
        exp_q.delete();
        tag_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: completions pop the expected tag order, grants pop the expected grant order.
    always @(negedge clk) begin
        if (!rst) begin
            if (dma_resp) begin
                if (tag_q.size() == 0) begin
                    check_eq("resp_spurious", resp, 0);
                end else begin
                    check_eq("resp_owner", resp, 1 << tag_q.pop_front());
                end
            end else begin
                check_eq("resp_quiet", resp, 0);
            end
            if (|req_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("grant_unexpected", req_ready, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("grant_id", req_ready, 1 << e.id);
                    check_eq("grant_xfer", xfer_out, e.xfer);
                    tag_q.push_back(e.id);
                    gnt_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_xfer  = '0;
        dma_rdy   = 1'b0;
        dma_resp  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_valid", xfer_vld, 0);
        check_eq("rst_xfer", xfer_out, 0);
        check_eq("rst_resp", resp, 0);
        check_eq("rst_inflight", inflight, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester, three back-to-back transfers.
        dma_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid   = 2'b01;
            req_xfer[0] = xfer_t'(8'hA0 + k);
            exp_gnt(0, xfer_t'(8'hA0 + k));
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        check_eq("single_gnt_cnt", gnt_cnt, 3);
        check_eq("single_inflight3", inflight, 3);
        tick();
        resp_n(3);
        @(negedge clk);
        check_eq("single_inflight0", inflight, 0);
        check_eq("single_idle", idle, 1);
        tick();

        // Contention: grants alternate 0,1,0,1.
        do_reset();
        dma_rdy     = 1'b1;
        req_valid   = 2'b11;
        req_xfer[0] = 8'h10;
        req_xfer[1] = 8'h21;
        exp_gnt(0, 8'h10);
        exp_gnt(1, 8'h21);
        exp_gnt(0, 8'h10);
        exp_gnt(1, 8'h21);
        repeat (4) tick();
        req_valid = '0;
        wait_drain();
        tick();
        resp_n(4);
        @(negedge clk);
        check_eq("cont_inflight0", inflight, 0);
        check_eq("cont_err", err, 0);
        tick();

        // Lock-in: req1 held while req0 joins, then both served in order.
        dma_rdy     = 1'b0;
        req_xfer[0] = 8'h44;
        req_xfer[1] = 8'h33;
        for (int c = 0; c < 4; c++) begin
            req_valid = (c >= 2) ? 2'b11 : 2'b10;
            @(negedge clk);
            check_eq("lock_xfer", xfer_out, 8'h33);
            check_eq("lock_valid", xfer_vld, 1);
            tick();
        end
        dma_rdy = 1'b1;
        exp_gnt(1, 8'h33);
        tick();
        req_valid = 2'b01;
        exp_gnt(0, 8'h44);
        tick();
        req_valid = '0;
        wait_drain();
        tick();
        resp_n(2);

        // Full gating with MAX_INFLIGHT = 4.
        do_reset();
        dma_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid   = 2'b01;
            req_xfer[0] = xfer_t'(8'hB0 + k);
            exp_gnt(0, xfer_t'(8'hB0 + k));
            tick();
        end
        req_valid   = 2'b10;
        req_xfer[1] = 8'h55;
        @(negedge clk);
        check_eq("full_valid", xfer_vld, 0);
        check_eq("full_inflight", inflight, 4);
        tick();
        dma_resp = 1'b1;
        @(negedge clk);
        check_eq("full_pop_blocks", xfer_vld, 0);
        tick();
        dma_resp = 1'b0;
        exp_gnt(1, 8'h55);
        @(negedge clk);
        check_eq("full_regrant", xfer_vld, 1);
        tick();
        req_valid = '0;
        wait_drain();
        resp_n(4);
        @(negedge clk);
        check_eq("full_inflight0", inflight, 0);
        tick();

        // Spurious completion with nothing outstanding.
        dma_resp = 1'b1;
        tick();
        dma_resp = 1'b0;
        @(negedge clk);
        check_eq("spur_err", err, 1);
        check_eq("spur_inflight", inflight, 0);
        tick();
        tick();
        check_eq("spur_err_sticky", err, 1);

        // Reset while locked with two outstanding; rr_ptr left at 1 beforehand.
        dma_rdy     = 1'b1;
        req_valid   = 2'b10;
        req_xfer[1] = 8'h61;
        exp_gnt(1, 8'h61);
        tick();
        req_valid   = 2'b01;
        req_xfer[0] = 8'h62;
        exp_gnt(0, 8'h62);
        tick();
        dma_rdy     = 1'b0;
        req_valid   = 2'b10;
        req_xfer[1] = 8'h63;
        tick();
        @(negedge clk);
        check_eq("rl_inflight2", inflight, 2);
        check_eq("rl_busy", idle, 0);
        check_eq("rl_locked_xfer", xfer_out, 8'h63);
        tick();
        do_reset();
        @(negedge clk);
        check_eq("rl_idle", idle, 1);
        check_eq("rl_inflight0", inflight, 0);
        check_eq("rl_err_clr", err, 0);
        tick();
        dma_rdy     = 1'b1;
        req_valid   = 2'b11;
        req_xfer[0] = 8'h70;
        req_xfer[1] = 8'h71;
        exp_gnt(0, 8'h70);
        tick();
        req_valid = '0;
        wait_drain();
        resp_n(1);
        resp_n(1);
        @(negedge clk);
        check_eq("post_rst_spur_err", err, 1);
        check_eq("final_tags", tag_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
